// File: rtl/expr_char_if.sv
// Load and character-stream bus between an expression source and the ASCII transmitter.
// master = transmitter side, slave = source/sink side.
interface expr_char_if #(
  parameter int unsigned MAX_TERMS = 4
);
  localparam int unsigned DW = 4 * MAX_TERMS;
  localparam int unsigned OW = MAX_TERMS - 1;

  logic          start;
  logic [3:0]    term_cnt;
  logic [DW-1:0] digits;
  logic [OW-1:0] ops;
  logic [7:0]    out_char;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, term_cnt, digits, ops, out_ready,
    output out_char, out_valid, busy, done, err
  );

  modport slave (
    output start, term_cnt, digits, ops, out_ready,
    input  out_char, out_valid, busy, done, err
  );
endinterface

// File: rtl/expr_char_tx.sv
// Serializes a packed BCD expression as ASCII characters over a valid/ready stream.
// Optional EXPR_TX_TERMINATOR_EN appends '=' after the final digit.
module expr_char_tx #(
  parameter int unsigned MAX_TERMS = 4
) (
  input logic        clk,
  input logic        clr_n,
  expr_char_if.master bus
);
  localparam int unsigned KW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam logic [7:0] CH_NUL  = 8'h00;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
`ifdef EXPR_TX_TERMINATOR_EN
  localparam logic [7:0] CH_EQ   = 8'h3D;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
`ifdef EXPR_TX_TERMINATOR_EN
    OP   = 2'd2,
    END  = 2'd3
`else
    OP   = 2'd2
`endif
  } state_t;

  // Latched expression; ops padded to MAX_TERMS so it shares the digit index.
  typedef struct packed {
    logic [MAX_TERMS-1:0][3:0] dig;
    logic [MAX_TERMS-1:0]      ops;
    logic [KW-1:0]             last;
  } expr_t;

  state_t                    state;
  expr_t                     expr;
  logic [KW-1:0]             k;
  logic [7:0]                out_char;
  logic                      out_valid;
  logic                      busy;
  logic                      done;
  logic                      err;

  logic [MAX_TERMS-1:0][3:0] dig_in_c;
  logic                      reject_c;

  assign dig_in_c = bus.digits;

  // Only the terms that will actually be sent must be legal BCD.
  always_comb begin
    reject_c = (bus.term_cnt == 4'd0) || (bus.term_cnt > 4'(MAX_TERMS));
    for (int i = 0; i < int'(MAX_TERMS); i++) begin
      if ((4'(i) < bus.term_cnt) && (dig_in_c[KW'(i)] > 4'd9)) begin
        reject_c = 1'b1;
      end
    end
  end

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return op ? CH_STAR : CH_PLUS;
  endfunction

  // Character sequencer; out_valid is high in every non-IDLE state, so acceptance is out_ready.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      expr      <= '0;
      k         <= '0;
      out_char  <= CH_NUL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (reject_c) begin
              err <= 1'b1;
            end else begin
              expr.dig  <= dig_in_c;
              expr.ops  <= {1'b0, bus.ops};
              expr.last <= KW'(bus.term_cnt - 4'd1);
              k         <= '0;
              state     <= NUM;
              out_char  <= digit_char(dig_in_c[0]);
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end

        NUM: begin
          if (bus.out_ready) begin
            if (k == expr.last) begin
`ifdef EXPR_TX_TERMINATOR_EN
              state    <= END;
              out_char <= CH_EQ;
`else
              state     <= IDLE;
              out_char  <= CH_NUL;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              state    <= OP;
              out_char <= op_char(expr.ops[k]);
            end
          end
        end

        OP: begin
          if (bus.out_ready) begin
            k        <= k + KW'(1);
            state    <= NUM;
            out_char <= digit_char(expr.dig[k + KW'(1)]);
          end
        end

`ifdef EXPR_TX_TERMINATOR_EN
        END: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_char  <= CH_NUL;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif

        default: begin
          state     <= IDLE;
          out_char  <= CH_NUL;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_char  = out_char;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule
